// File: rtl/ntt_stage_ctrl_if.sv
// Handshake/status bundle between the NTT stage sequencer and its environment.
// The master side is the sequencer; the slave side is the top-level controller.
interface ntt_stage_ctrl_if #(
  parameter int LOGN     = 8,
  parameter int RADIX_K1 = 4
);
  logic                       start;
  logic                       abort;
  logic                       tw_ready;
  logic                       agu_enable;
  logic [2:0]                 stage;
  logic [LOGN-RADIX_K1-1:0]   issue_cnt;
  logic                       rd_bank;
  logic                       wr_en;
  logic                       wr_bank;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, abort, tw_ready,
    output agu_enable, stage, issue_cnt, rd_bank, wr_en, wr_bank, busy, done
  );

  modport slave (
    output start, abort, tw_ready,
    input  agu_enable, stage, issue_cnt, rd_bank, wr_en, wr_bank, busy, done
  );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// NTT stage sequencer: one contiguous address-group pass per stage, a drain gap
// covering the butterfly latency, a delayed write strobe and ping-pong bank selects.
module ntt_stage_ctrl #(
  parameter int LOGN     = 8,
  parameter int RADIX_K1 = 4,
  parameter int STAGES   = LOGN / RADIX_K1,
  parameter int PE_LAT   = 8,
  parameter int G        = 2 ** (LOGN - RADIX_K1)
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_stage_ctrl_if.master      bus
);
  localparam int GW     = LOGN - RADIX_K1;
  localparam int PIPE_D = PE_LAT + 1;
  localparam int DW     = $clog2(PE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TW, ISSUE, DRAIN, FIN
  } state_t;

  state_t                   r_state;
  logic [2:0]               r_stage;
  logic [GW-1:0]            r_issue_cnt;
  logic [DW-1:0]            r_drain_cnt;
  logic                     r_agu_en;
  logic                     r_busy;
  logic                     r_done;
  // Each entry is {valid, bank}; the oldest entry sits at the top index.
  logic [PIPE_D-1:0][1:0]   r_wr_pipe;
  logic [1:0]               w_wr_head;

  // NOTE: every piece of state, the write pipe included, uses <= so all flops
  // update from pre-edge values; the pipe is plain flops, so it is reset too,
  // which is what lets abort guarantee no stray wr_en afterwards.
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      r_state     <= IDLE;
      r_stage     <= '0;
      r_issue_cnt <= '0;
      r_drain_cnt <= '0;
      r_agu_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_pipe   <= '0;
    end else begin
      r_wr_pipe <= {r_wr_pipe[PIPE_D-2:0], r_agu_en, r_agu_en & ~r_stage[0]};
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= WAIT_TW;
            r_busy      <= 1'b1;
            r_stage     <= '0;
            r_issue_cnt <= '0;
          end
        end
        WAIT_TW: begin
          if (bus.tw_ready) begin
            r_state  <= ISSUE;
            r_agu_en <= 1'b1;
          end
        end
        ISSUE: begin
          // The pass cannot pause: the address generator restarts if enable drops.
          r_issue_cnt <= r_issue_cnt + GW'(1);
          if (r_issue_cnt == GW'(G - 1)) begin
            r_state     <= DRAIN;
            r_agu_en    <= 1'b0;
            r_drain_cnt <= DW'(PE_LAT);
          end
        end
        DRAIN: begin
          if (r_drain_cnt == '0) begin
            if (r_stage == 3'(STAGES - 1)) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_stage <= r_stage + 3'd1;
              r_state <= WAIT_TW;
            end
          end else begin
            r_drain_cnt <= r_drain_cnt - DW'(1);
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_stage <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_wr_head      = r_wr_pipe[PIPE_D-1];
  assign bus.agu_enable = r_agu_en;
  assign bus.stage      = r_stage;
  assign bus.issue_cnt  = r_issue_cnt;
  assign bus.rd_bank    = r_stage[0];
  assign bus.wr_en      = w_wr_head[1];
  assign bus.wr_bank    = w_wr_head[0];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: expected issue, write and done events are
// queued from the timing rules when a run is launched and popped as the DUT emits them.
module tb_ntt_stage_ctrl;
  localparam int G   = 16;
  localparam int PE  = 8;
  localparam int ST  = 2;
  localparam int PER = G + PE + 2;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_stage_ctrl_if #(.LOGN(8),  .RADIX_K1(4)) bus_a ();
  ntt_stage_ctrl_if #(.LOGN(12), .RADIX_K1(4)) bus_b ();

  ntt_stage_ctrl #(.LOGN(8), .RADIX_K1(4), .PE_LAT(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ntt_stage_ctrl #(.LOGN(12), .RADIX_K1(4), .PE_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct { int cyc; logic [2:0] stage; logic [3:0] icnt; } agu_t;
  typedef struct { int cyc; logic bank; } wr_t;

  agu_t q_agu[$];
  wr_t  q_wr[$];
  int   q_done[$];
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   mon_en  = 1'b0;
  agu_t a_exp;
  wr_t  w_exp;
  int   d_exp;

  int   b_agu = 0, b_wr = 0, b_done = 0, b_done_cyc = -1, b_first_agu = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Expected events for one run starting in cycle t0; nothing at or after cut+1.
  task automatic plan(input int t0, input int extra, input int cut);
    int s;
    int dn;
    s = t0;
    for (int l = 0; l < ST; l++) begin
      s = t0 + 2 + l * PER + ((l > 0) ? extra : 0);
      for (int i = 0; i < G; i++) begin
        if (s + i <= cut)          q_agu.push_back('{s + i, 3'(l), 4'(i)});
        if (s + i + 1 + PE <= cut) q_wr.push_back('{s + i + 1 + PE, (l % 2 == 0)});
      end
    end
    dn = s + G + PE + 1;
    if (dn <= cut) q_done.push_back(dn);
    busy_lo = t0 + 1;
    busy_hi = (dn < cut) ? dn : cut;
  endtask

  task automatic run(input int n, input int s0, input int s1, input int s2, input int s3,
                     input int tw_lo, input int tw_hi, input int ab, input int rs);
    for (int k = 0; k < n; k++) begin
      bus_a.start    = (k == s0 || k == s1 || k == s2 || k == s3);
      bus_a.tw_ready = !(k >= tw_lo && k <= tw_hi);
      bus_a.abort    = (k == ab);
      rst            = (k == rs);
      @(posedge clk);
      #1;
    end
    bus_a.start    = 1'b0;
    bus_a.tw_ready = 1'b1;
    bus_a.abort    = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic end_check(input string name);
    check({name, "_agu_left"},  q_agu.size(),  0);
    check({name, "_wr_left"},   q_wr.size(),   0);
    check({name, "_done_left"}, q_done.size(), 0);
    q_agu.delete();
    q_wr.delete();
    q_done.delete();
    busy_lo = 1;
    busy_hi = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", bus_a.busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (bus_a.agu_enable) begin
        if (q_agu.size() == 0) check("agu_spurious", 1, 0);
        else begin
          a_exp = q_agu.pop_front();
          check("agu_cycle", cyc, a_exp.cyc);
          check("stage", bus_a.stage, a_exp.stage);
          check("issue_cnt", bus_a.issue_cnt, a_exp.icnt);
          check("rd_bank", bus_a.rd_bank, a_exp.stage[0]);
        end
      end
      if (bus_a.wr_en) begin
        if (q_wr.size() == 0) check("wr_spurious", 1, 0);
        else begin
          w_exp = q_wr.pop_front();
          check("wr_cycle", cyc, w_exp.cyc);
          check("wr_bank", bus_a.wr_bank, w_exp.bank);
        end
      end
      if (bus_a.done) begin
        if (q_done.size() == 0) check("done_spurious", 1, 0);
        else begin
          d_exp = q_done.pop_front();
          check("done_cycle", cyc, d_exp);
        end
      end
    end
    if (bus_b.agu_enable) begin
      if (b_first_agu < 0) b_first_agu = cyc;
      b_agu++;
    end
    if (bus_b.wr_en) b_wr++;
    if (bus_b.done) begin
      b_done++;
      b_done_cyc = cyc;
    end
  end

  initial begin
    int t0;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.tw_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.tw_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_agu",     bus_a.agu_enable, 0);
    check("rst_stage",   bus_a.stage,      0);
    check("rst_icnt",    bus_a.issue_cnt,  0);
    check("rst_rd_bank", bus_a.rd_bank,    0);
    check("rst_wr_en",   bus_a.wr_en,      0);
    check("rst_wr_bank", bus_a.wr_bank,    0);
    check("rst_busy",    bus_a.busy,       0);
    check("rst_done",    bus_a.done,       0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Nominal run, tw_ready held high.
    t0 = cyc;
    plan(t0, 0, BIG);
    run(60, 0, -1, -1, -1, -1, -2, -1, -1);
    end_check("nominal");

    // Twiddle not ready for 5 cycles at the stage-1 boundary.
    t0 = cyc;
    plan(t0, 5, BIG);
    run(65, 0, -1, -1, -1, 27, 31, -1, -1);
    end_check("tw_stall");

    // Abort during the stage-0 pass.
    t0 = cyc;
    plan(t0, 0, t0 + 10);
    run(11, 0, -1, -1, -1, -1, -2, 10, -1);
    check("abort_agu",   bus_a.agu_enable, 0);
    check("abort_stage", bus_a.stage,      0);
    check("abort_icnt",  bus_a.issue_cnt,  0);
    check("abort_wr_en", bus_a.wr_en,      0);
    check("abort_busy",  bus_a.busy,       0);
    check("abort_done",  bus_a.done,       0);
    run(30, -1, -1, -1, -1, -1, -2, -1, -1);
    end_check("abort");

    // Extra start pulses while busy must not disturb the run.
    t0 = cyc;
    plan(t0, 0, BIG);
    run(62, 0, 5, 20, 53, -1, -2, -1, -1);
    end_check("start_busy");

    // abort and start together in IDLE: nothing starts.
    run(12, 0, -1, -1, -1, -1, -2, 0, -1);
    end_check("abort_start");

    // Synchronous reset in stage 1 acts like abort.
    t0 = cyc;
    plan(t0, 0, t0 + 30);
    run(45, 0, -1, -1, -1, -1, -2, -1, 30);
    end_check("mid_reset");

    // Larger configuration: 3 stages of 256 groups, PE_LAT=3.
    t0 = cyc;
    bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    run(799, -1, -1, -1, -1, -1, -2, -1, -1);
    check("b_first_agu", b_first_agu - t0, 2);
    check("b_agu_count", b_agu,            768);
    check("b_wr_count",  b_wr,             768);
    check("b_done_count", b_done,          1);
    check("b_done_cycle", b_done_cyc - t0, 784);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
